// File: rtl/accumulator_dump.sv
// accumulator_dump: integrate-and-dump accumulator.
//   Sums input samples into a running register. When a non-zero window length
//   is programmed, every iLen accepted samples the window total is moved to a
//   held dump register and a one-cycle valid strobe is raised. Arithmetic can
//   be signed or unsigned, and can saturate or wrap. A sticky flag records any
//   overflow until clear or reset.
// Ports:
//   iClk        clock, all logic on rising edge
//   iRst        synchronous reset, active-low
//   iCe         sample enable
//   iClr        synchronous clear of sum, window counter and overflow flag
//   iLen        window length in samples (0 = free-running, no dumps)
//   iIn         input sample
//   oOut        running sum register
//   oDump       last completed window sum
//   oDumpValid  one-cycle strobe, oDump updated
//   oOvf        sticky overflow flag
module accumulator_dump #(
   parameter int IN_W   = 12,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16,
   parameter bit SIGNED = 1'b0,
   parameter bit SAT    = 1'b0
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iCe,
   input  logic             iClr,
   input  logic [CNT_W-1:0] iLen,
   input  logic [IN_W-1:0]  iIn,
   output logic [ACC_W-1:0] oOut,
   output logic [ACC_W-1:0] oDump,
   output logic             oDumpValid,
   output logic             oOvf
);

   localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W:0]   ext_in;
   logic [ACC_W:0]   acc_x;
   logic [ACC_W:0]   sum_x;
   logic             ovf_now;
   logic [ACC_W-1:0] res;
   logic             last;

   // Operands widened by one bit so the carry (unsigned) is visible.
   always_comb begin
      if (SIGNED) begin
         ext_in = {{(ACC_W+1-IN_W){iIn[IN_W-1]}}, iIn};
         acc_x  = {acc[ACC_W-1], acc};
      end else begin
         ext_in = {{(ACC_W+1-IN_W){1'b0}}, iIn};
         acc_x  = {1'b0, acc};
      end
   end

   assign sum_x = acc_x + ext_in;

   always_comb begin
      res = sum_x[ACC_W-1:0];
      if (SIGNED) begin
         // Same-sign operands whose result flips sign.
         ovf_now = (acc[ACC_W-1] == ext_in[ACC_W-1]) &&
                   (sum_x[ACC_W-1] != acc[ACC_W-1]);
         // Direction of a signed overflow follows the shared operand sign.
         if (SAT && ovf_now) res = acc[ACC_W-1] ? S_MIN : S_MAX;
      end else begin
         ovf_now = sum_x[ACC_W];
         // Adding a non-negative value can only overflow upward.
         if (SAT && ovf_now) res = U_MAX;
      end
   end

   // '>=' rather than '==' so that shrinking iLen mid-window dumps promptly.
   assign last = (iLen != '0) && (cnt >= (iLen - CNT_W'(1)));

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         acc        <= '0;
         cnt        <= '0;
         oDump      <= '0;
         oDumpValid <= 1'b0;
         oOvf       <= 1'b0;
      end else begin
         oDumpValid <= 1'b0;
         if (iClr) begin
            acc  <= '0;
            cnt  <= '0;
            oOvf <= 1'b0;
         end else if (iCe) begin
            if (ovf_now) oOvf <= 1'b1;
            if (iLen == '0) begin
               acc <= res;
            end else if (last) begin
               oDump      <= res;
               oDumpValid <= 1'b1;
               acc        <= '0;
               cnt        <= '0;
            end else begin
               acc <= res;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign oOut = acc;

endmodule

// File: tb/tb_accumulator_dump.sv
// Directed bench for accumulator_dump. Four instances share the stimulus:
// default config, 13-bit saturating, 13-bit wrapping and 32-bit signed.
module tb_accumulator_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        clr;
   logic [15:0] len;
   logic [11:0] din;

   logic [31:0] d_out, d_dump;
   logic        d_vld, d_ovf;
   logic [12:0] s_out, s_dump;
   logic        s_vld, s_ovf;
   logic [12:0] w_out, w_dump;
   logic        w_vld, w_ovf;
   logic [31:0] g_out, g_dump;
   logic        g_vld, g_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   accumulator_dump u_def (
      .iClk(clk), .iRst(rst), .iCe(ce), .iClr(clr), .iLen(len), .iIn(din),
      .oOut(d_out), .oDump(d_dump), .oDumpValid(d_vld), .oOvf(d_ovf));

   accumulator_dump #(.ACC_W(13), .SAT(1'b1)) u_sat (
      .iClk(clk), .iRst(rst), .iCe(ce), .iClr(clr), .iLen(len), .iIn(din),
      .oOut(s_out), .oDump(s_dump), .oDumpValid(s_vld), .oOvf(s_ovf));

   accumulator_dump #(.ACC_W(13), .SAT(1'b0)) u_wrap (
      .iClk(clk), .iRst(rst), .iCe(ce), .iClr(clr), .iLen(len), .iIn(din),
      .oOut(w_out), .oDump(w_dump), .oDumpValid(w_vld), .oOvf(w_ovf));

   accumulator_dump #(.SIGNED(1'b1)) u_sgn (
      .iClk(clk), .iRst(rst), .iCe(ce), .iClr(clr), .iLen(len), .iIn(din),
      .oOut(g_out), .oDump(g_dump), .oDumpValid(g_vld), .oOvf(g_ovf));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ce = 1'b1; clr = 1'b0; len = 16'd3; din = 12'd5;

      // reset holds everything at zero despite active inputs
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_out",  d_out,  0);
         chk("rst_dump", d_dump, 0);
         chk("rst_vld",  d_vld,  0);
         chk("rst_ovf",  d_ovf,  0);
      end
      rst = 1'b1;

      // free-running
      len = 16'd0; din = 12'hFFF;
      step(); chk("fr_out1", d_out, 4095);  chk("fr_vld1", d_vld, 0);
      step(); chk("fr_out2", d_out, 8190);  chk("fr_vld2", d_vld, 0);
      step(); chk("fr_out3", d_out, 12285); chk("fr_vld3", d_vld, 0);

      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_out", d_out, 0);

      // window of 4
      len = 16'd4;
      din = 12'd1; step(); chk("w_out1", d_out, 1);
      din = 12'd2; step(); chk("w_out2", d_out, 3);
      din = 12'd3; step(); chk("w_out3", d_out, 6); chk("w_vld3", d_vld, 0);
      din = 12'd4; step();
      chk("w_dump", d_dump, 10); chk("w_vld4", d_vld, 1); chk("w_out4", d_out, 0);
      din = 12'd5; step();
      chk("w_out5", d_out, 5); chk("w_vld5", d_vld, 0); chk("w_dump5", d_dump, 10);

      clr = 1'b1; step(); clr = 1'b0;

      // enable gaps, window of 2
      len = 16'd2; din = 12'd7;
      ce = 1'b1; step(); chk("g_out1", d_out, 7); chk("g_vld1", d_vld, 0);
      ce = 1'b0; step(); chk("g_out2", d_out, 7); chk("g_vld2", d_vld, 0);
      step();            chk("g_vld3", d_vld, 0);
      ce = 1'b1; step();
      chk("g_dump", d_dump, 14); chk("g_vld4", d_vld, 1); chk("g_out4", d_out, 0);
      ce = 1'b0; step(); chk("g_vld5", d_vld, 0); chk("g_dump5", d_dump, 14);

      // same pattern, clear collides with the would-be dump
      ce = 1'b1; step(); chk("c_out1", d_out, 7);
      ce = 1'b0; step(); step();
      ce = 1'b1; clr = 1'b1; step(); clr = 1'b0;
      chk("c_vld", d_vld, 0); chk("c_dump", d_dump, 14); chk("c_out", d_out, 0);

      // iLen=1: every sample dumps, running sum stays zero
      len = 16'd1; din = 12'd9; step();
      chk("l1_dump", d_dump, 9); chk("l1_vld", d_vld, 1); chk("l1_out", d_out, 0);
      din = 12'd3; step();
      chk("l1_dump2", d_dump, 3); chk("l1_vld2", d_vld, 1); chk("l1_out2", d_out, 0);

      // reset mid-window discards partial sum and the dump
      len = 16'd3; din = 12'd1; step(); chk("rm_out", d_out, 1);
      rst = 1'b0; step(); rst = 1'b1;
      chk("rm_out0", d_out, 0); chk("rm_dump0", d_dump, 0);

      // overflow: 13-bit sat / wrap, and signed 32-bit
      clr = 1'b1; step(); clr = 1'b0;
      len = 16'd0; din = 12'hFFF; ce = 1'b1;
      step();
      chk("o_sat1", s_out, 4095); chk("o_wrp1", w_out, 4095);
      chk("sg_out1", g_out, 32'hFFFF_FFFF);
      step();
      chk("o_sat2", s_out, 8190); chk("o_wrp2", w_out, 8190);
      chk("o_sovf2", s_ovf, 0);   chk("o_wovf2", w_ovf, 0);
      chk("sg_out2", g_out, 32'hFFFF_FFFE);
      din = 12'h002; step();
      chk("sg_out3", g_out, 0); chk("sg_ovf3", g_ovf, 0);
      // third 0xFFF for the 13-bit units came out as 0x002 above; redo cleanly
      clr = 1'b1; step(); clr = 1'b0;
      din = 12'hFFF;
      step(); step(); step();
      chk("o_sat3", s_out, 8191); chk("o_sovf3", s_ovf, 1);
      chk("o_wrp3", w_out, 4093); chk("o_wovf3", w_ovf, 1);
      ce = 1'b0; step();
      chk("o_shold", s_ovf, 1); chk("o_sout_hold", s_out, 8191);
      clr = 1'b1; step(); clr = 1'b0;
      chk("o_sclr", s_ovf, 0); chk("o_wclr", w_ovf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
